auth_responder: RTL and testbench
=================================

// Module: auth_responder
// PURPOSE
//  USB Type-C Authentication responder: the device-side end of the authentication
//  exchange. Accepts GET_DIGESTS, GET_CERTIFICATE and CHALLENGE requests and builds
//  DIGESTS, CERTIFICATE, CHALLENGE_AUTH or ERROR responses.
//  Digests and certificate chains are fetched from a byte-wide store; CHALLENGE
//  signing is handed to an external crypto engine.
// PARAMETERS
//  PAYLOAD_BYTES  128    max response payload bytes (>=128)
//  CERT_LEN       512    bytes per slot certificate chain; slot s at base s*CERT_LEN
//  DIGEST_BASE    2048   store address of slot-0 digest; slot s at DIGEST_BASE+32*s
//  ADDR_W         12     store address width
//  CHAL_TIMEOUT   4096   cycles to wait for chal_done
// PORTS
//  clk              in   1        clock, all logic on posedge
//  reset            in   1        asynchronous, active-low reset
//  msg_req_in       in   1        request present on header_in/payload_in
//  header_in        in   32       [31:24]ProtocolVersion [23:16]MessageType [15:8]Param1 [7:0]Param2
//  payload_in       in   8*PAYLOAD_BYTES  request payload, byte i at [8i+7:8i]
//  Ack_in           in   1        consumer has taken the response
//  slot_mask        in   4        populated certificate slots
//  mem_rd_en        out  1        store read strobe
//  mem_addr         out  ADDR_W   store byte address
//  mem_rd_data      in   8        store data, valid exactly 1 cycle after mem_rd_en
//  chal_start       out  1        one-cycle pulse to crypto engine
//  chal_slot        out  2        slot to sign with
//  chal_nonce       out  256      nonce, request payload bytes 0..31
//  chal_done        in   1        crypto result valid (sampled only in CHAL_WAIT)
//  chal_resp        in   8*PAYLOAD_BYTES  CHALLENGE_AUTH payload
//  chal_len         in   16       valid bytes in chal_resp
//  Ack_out          out  1        one-cycle pulse: request accepted
//  pending_auth_msg_to_send out 1 response valid, held until Ack_in
//  header           out  32       response header, same packing as header_in
//  payload          out  8*PAYLOAD_BYTES  response payload, unused bytes zero
//  wLength          out  16       4 + valid payload bytes
// BEHAVIOUR
//  Reset (async, active-low): all outputs 0; state IDLE; request registers cleared.
//  States: IDLE, DECODE, DIGESTS, CERT_RD, CHAL_WAIT, BUILD_ERR, SEND_MSG, WAIT_ACK.
//  IDLE: msg_req_in=1 at posedge -> latch header_in/payload_in, Ack_out=1 next cycle (1 cycle), ->DECODE.
//   Requests are accepted only in IDLE; msg_req_in is ignored in all other states.
//  DECODE (1 cycle):
//   ProtocolVersion!=0x01 -> BUILD_ERR code 0x02.
//   MessageType 0x81 -> DIGESTS.
//   0x82 -> CERT_RD if slot_mask[Param1[1:0]]=1, offset<CERT_LEN and length!=0; else BUILD_ERR code 0x01.
//    offset = payload bytes 1:0, little-endian; length = bytes 3:2.
//   0x83 -> CHAL_WAIT if slot populated, else BUILD_ERR 0x01.
//   Any other MessageType -> BUILD_ERR 0x01.
//  DIGESTS: reads 32 bytes per populated slot, ascending slot order, one byte per cycle pipelined.
//   Response header {01,01,00,slot_mask}; wLength=4+32*popcount(slot_mask).
//  CERT_RD: n=min(length,PAYLOAD_BYTES,CERT_LEN-offset) bytes.
//   Reads addresses slot*CERT_LEN+offset .. +n-1, one per cycle; byte k written to payload byte k.
//   Header {01,02,slot,00}; wLength=4+n.
//  CHAL_WAIT: chal_start pulses on entry; chal_slot/chal_nonce held stable while in state.
//   chal_done -> header {01,03,slot,00}, payload=chal_resp, wLength=4+min(chal_len,PAYLOAD_BYTES).
//   CHAL_TIMEOUT cycles without chal_done -> BUILD_ERR code 0xFF.
//  BUILD_ERR (1 cycle): header {01,7F,code,00}, payload 0, wLength=4.
//  SEND_MSG: pending_auth_msg_to_send=1. header/payload/wLength stable until Ack_in sampled 1 -> WAIT_ACK.
//  WAIT_ACK: pending=0, -> IDLE next cycle. msg_req_in concurrent with Ack_in is accepted only from IDLE.
//  Payload register cleared at each request accept; mem_rd_en=0 outside DIGESTS/CERT_RD.
//  Reset asserted mid-transfer: response discarded, no pending or Ack_out glitch after release.
// TESTING
//  1 GET_DIGESTS {01,81,00,00}, slot_mask=0101 -> header 0x01010005, wLength=68, payload = slot0 then slot2 digests.
//  2 GET_CERTIFICATE slot1, offset 500, length 64 -> n=12, addrs 1012..1023, wLength=16, bytes 12+ zero.
//  3 CHALLENGE slot0; chal_done 10 cycles after chal_start, chal_len=100 -> header 0x01030000, wLength=104.
//   Repeat with chal_done never asserted -> after 4096 cycles, ERROR 0x017FFF00.
//  4 Version 0x02 -> ERROR code 0x02.
//   MessageType 0x84 -> code 0x01.
//   GET_CERTIFICATE to empty slot -> code 0x01; wLength=4 in all three cases.
//  5 Hold Ack_in=0 for 20 cycles -> outputs stable, pending=1.
//   msg_req_in during that time -> no Ack_out.
//   Ack_in then msg_req_in -> accepted 2 cycles later.
//  6 reset low mid-CERT_RD -> all outputs 0 immediately; next GET_CERTIFICATE completes correctly.

Source files
------------

// File: rtl/auth_responder.sv
// Device-side USB Type-C authentication responder: decodes GET_DIGESTS, GET_CERTIFICATE
// and CHALLENGE requests, gathers data from a byte store or a crypto engine, returns a response.
module auth_responder #(
    parameter int PAYLOAD_BYTES = 128,
    parameter int CERT_LEN      = 512,
    parameter int DIGEST_BASE   = 2048,
    parameter int ADDR_W        = 12,
    parameter int CHAL_TIMEOUT  = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         msg_req_in,
    input  logic [31:0]                  header_in,
    input  logic [8*PAYLOAD_BYTES-1:0]   payload_in,
    input  logic                         Ack_in,
    input  logic [3:0]                   slot_mask,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [7:0]                   mem_rd_data,
    output logic                         chal_start,
    output logic [1:0]                   chal_slot,
    output logic [255:0]                 chal_nonce,
    input  logic                         chal_done,
    input  logic [8*PAYLOAD_BYTES-1:0]   chal_resp,
    input  logic [15:0]                  chal_len,
    output logic                         Ack_out,
    output logic                         pending_auth_msg_to_send,
    output logic [31:0]                  header,
    output logic [8*PAYLOAD_BYTES-1:0]   payload,
    output logic [15:0]                  wLength,
    output logic [2:0]                   dbg_state
);
    localparam int PW = 8*PAYLOAD_BYTES;
    localparam int IW = $clog2(PAYLOAD_BYTES);
    localparam int TW = $clog2(CHAL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, DIGESTS, CERT_RD, CHAL_WAIT, BUILD_ERR, SEND_MSG, WAIT_ACK
    } state_t;

    state_t              state;
    logic [31:0]         req_hdr;
    logic [255:0]        req_pl;
    logic [3:0]          mask_q;
    logic [1:0]          cur_slot;
    logic [4:0]          byte_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [15:0]         rd_left;
    logic                issue_done;
    logic                cap_q;
    logic [IW-1:0]       wr_idx;
    logic [TW-1:0]       timer;
    logic [7:0]          err_code;

    logic [15:0]         req_off;
    logic [15:0]         req_len;
    logic [15:0]         cert_n;
    logic [15:0]         dig_len;
    logic [15:0]         chal_n;
    logic [ADDR_W-1:0]   cert_base;
    logic [ADDR_W-1:0]   dig_addr;
    logic                slot_ok;
    logic                unused_bits;

    assign dbg_state   = state;
    assign unused_bits = ^{payload_in[PW-1:256], req_hdr[15:10], req_hdr[7:0]};

    always_comb begin
        req_off   = req_pl[15:0];
        req_len   = req_pl[31:16];
        slot_ok   = slot_mask[req_hdr[9:8]];
        cert_n    = req_len;
        if (cert_n > 16'(PAYLOAD_BYTES)) cert_n = 16'(PAYLOAD_BYTES);
        if (cert_n > 16'(CERT_LEN) - req_off) cert_n = 16'(CERT_LEN) - req_off;
        cert_base = ADDR_W'(CERT_LEN) * ADDR_W'(req_hdr[9:8]) + ADDR_W'(req_off);
        dig_addr  = ADDR_W'(DIGEST_BASE) + ADDR_W'({cur_slot, byte_cnt});
        dig_len   = 16'd4;
        for (int i = 0; i < 4; i++) begin
            if (slot_mask[i]) dig_len = dig_len + 16'd32;
        end
        chal_n = (chal_len > 16'(PAYLOAD_BYTES)) ? 16'(PAYLOAD_BYTES) : chal_len;
    end

    // Response handshake: pending_auth_msg_to_send is the valid; it rises with header/payload/
    // wLength already final and all three hold until Ack_in is sampled high, then valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            req_hdr                  <= '0;
            req_pl                   <= '0;
            mask_q                   <= '0;
            cur_slot                 <= '0;
            byte_cnt                 <= '0;
            rd_addr                  <= '0;
            rd_left                  <= '0;
            issue_done               <= 1'b0;
            cap_q                    <= 1'b0;
            wr_idx                   <= '0;
            timer                    <= '0;
            err_code                 <= '0;
            mem_rd_en                <= 1'b0;
            mem_addr                 <= '0;
            chal_start               <= 1'b0;
            chal_slot                <= '0;
            chal_nonce               <= '0;
            Ack_out                  <= 1'b0;
            pending_auth_msg_to_send <= 1'b0;
            header                   <= '0;
            payload                  <= '0;
            wLength                  <= '0;
        end else begin
            Ack_out    <= 1'b0;
            chal_start <= 1'b0;
            mem_rd_en  <= 1'b0;
            // Store data lands one cycle after the strobe, so captures trail issues by one.
            cap_q      <= mem_rd_en;
            if (cap_q) begin
                payload[{wr_idx, 3'b000} +: 8] <= mem_rd_data;
                wr_idx <= wr_idx + IW'(1);
            end
            case (state)
                IDLE: begin
                    if (msg_req_in) begin
                        req_hdr <= header_in;
                        req_pl  <= payload_in[255:0];
                        payload <= '0;
                        Ack_out <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    mask_q     <= slot_mask;
                    wr_idx     <= '0;
                    issue_done <= 1'b0;
                    if (req_hdr[31:24] != 8'h01) begin
                        err_code <= 8'h02;
                        state    <= BUILD_ERR;
                    end else begin
                        case (req_hdr[23:16])
                            8'h81: begin
                                header     <= {8'h01, 8'h01, 8'h00, 4'd0, slot_mask};
                                wLength    <= dig_len;
                                cur_slot   <= 2'd0;
                                byte_cnt   <= 5'd0;
                                issue_done <= (slot_mask == 4'd0);
                                state      <= DIGESTS;
                            end
                            8'h82: begin
                                if (slot_ok && req_off < 16'(CERT_LEN) && req_len != 16'd0) begin
                                    header  <= {8'h01, 8'h02, 6'd0, req_hdr[9:8], 8'h00};
                                    wLength <= cert_n + 16'd4;
                                    rd_addr <= cert_base;
                                    rd_left <= cert_n;
                                    state   <= CERT_RD;
                                end else begin
                                    err_code <= 8'h01;
                                    state    <= BUILD_ERR;
                                end
                            end
                            8'h83: begin
                                if (slot_ok) begin
                                    chal_start <= 1'b1;
                                    chal_slot  <= req_hdr[9:8];
                                    chal_nonce <= req_pl;
                                    timer      <= '0;
                                    state      <= CHAL_WAIT;
                                end else begin
                                    err_code <= 8'h01;
                                    state    <= BUILD_ERR;
                                end
                            end
                            default: begin
                                err_code <= 8'h01;
                                state    <= BUILD_ERR;
                            end
                        endcase
                    end
                end
                DIGESTS: begin
                    if (!issue_done) begin
                        if (mask_q[cur_slot]) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= dig_addr;
                            byte_cnt  <= byte_cnt + 5'd1;
                        end
                        // Empty slots cost one idle cycle each; full slots advance after byte 31.
                        if (!mask_q[cur_slot] || byte_cnt == 5'd31) begin
                            if (cur_slot == 2'd3) issue_done <= 1'b1;
                            else                  cur_slot   <= cur_slot + 2'd1;
                        end
                    end else if (!mem_rd_en && !cap_q) begin
                        pending_auth_msg_to_send <= 1'b1;
                        state                    <= SEND_MSG;
                    end
                end
                CERT_RD: begin
                    if (!issue_done) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= rd_addr;
                        rd_addr   <= rd_addr + ADDR_W'(1);
                        rd_left   <= rd_left - 16'd1;
                        if (rd_left == 16'd1) issue_done <= 1'b1;
                    end else if (!mem_rd_en && !cap_q) begin
                        pending_auth_msg_to_send <= 1'b1;
                        state                    <= SEND_MSG;
                    end
                end
                CHAL_WAIT: begin
                    if (chal_done) begin
                        header                   <= {8'h01, 8'h03, 6'd0, chal_slot, 8'h00};
                        payload                  <= chal_resp;
                        wLength                  <= chal_n + 16'd4;
                        pending_auth_msg_to_send <= 1'b1;
                        state                    <= SEND_MSG;
                    end else if (timer == TW'(CHAL_TIMEOUT - 1)) begin
                        err_code <= 8'hFF;
                        state    <= BUILD_ERR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                BUILD_ERR: begin
                    header                   <= {8'h01, 8'h7F, err_code, 8'h00};
                    payload                  <= '0;
                    wLength                  <= 16'd4;
                    pending_auth_msg_to_send <= 1'b1;
                    state                    <= SEND_MSG;
                end
                SEND_MSG: begin
                    if (Ack_in) begin
                        pending_auth_msg_to_send <= 1'b0;
                        state                    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_auth_responder.sv
// Bench for auth_responder: directed cases plus random requests, scoreboard fed by a
// spec-level reference model, monitor comparing every presented response.
module tb_auth_responder;
    localparam int PB          = 128;
    localparam int PW          = 8*PB;
    localparam int CERT_LEN    = 512;
    localparam int DIGEST_BASE = 2048;
    localparam int RW          = 32 + 16 + PW;

    logic           clk = 1'b0;
    logic           reset;
    logic           msg_req_in;
    logic [31:0]    header_in;
    logic [PW-1:0]  payload_in;
    logic           Ack_in;
    logic [3:0]     slot_mask;
    logic           mem_rd_en;
    logic [11:0]    mem_addr;
    logic [7:0]     mem_rd_data;
    logic           chal_start;
    logic [1:0]     chal_slot;
    logic [255:0]   chal_nonce;
    logic           chal_done;
    logic [PW-1:0]  chal_resp;
    logic [15:0]    chal_len;
    logic           Ack_out;
    logic           pending_auth_msg_to_send;
    logic [31:0]    header;
    logic [PW-1:0]  payload;
    logic [15:0]    wLength;
    logic [2:0]     dbg_state;

    logic [7:0]     mem [0:4095];
    logic [RW-1:0]  exp_q[$];
    logic [11:0]    addr_log[$];
    int             checks = 0;
    int             errors = 0;

    auth_responder dut (
        .clk(clk), .reset(reset), .msg_req_in(msg_req_in), .header_in(header_in),
        .payload_in(payload_in), .Ack_in(Ack_in), .slot_mask(slot_mask),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .chal_start(chal_start), .chal_slot(chal_slot), .chal_nonce(chal_nonce),
        .chal_done(chal_done), .chal_resp(chal_resp), .chal_len(chal_len),
        .Ack_out(Ack_out), .pending_auth_msg_to_send(pending_auth_msg_to_send),
        .header(header), .payload(payload), .wLength(wLength), .dbg_state(dbg_state)
    );

    // Clock / store model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    function automatic logic [RW-1:0] model(input logic [31:0] h, input logic [255:0] pl,
                                            input logic [3:0] m, input logic [PW-1:0] cresp,
                                            input int clen, input bit cdone);
        logic [31:0] eh;
        logic [PW-1:0] ep;
        int el, slot, off, len, n, k;
        ep   = '0;
        slot = int'(h[9:8]);
        off  = int'(pl[15:0]);
        len  = int'(pl[31:16]);
        if (h[31:24] != 8'h01) begin
            eh = 32'h017F0200; el = 4;
        end else if (h[23:16] == 8'h81) begin
            k = 0;
            for (int s = 0; s < 4; s++)
                if (m[s])
                    for (int b = 0; b < 32; b++) begin
                        ep[8*k +: 8] = mem[DIGEST_BASE + 32*s + b];
                        k++;
                    end
            eh = {24'h010100, 4'h0, m}; el = 4 + k;
        end else if (h[23:16] == 8'h82 && m[slot] && off < CERT_LEN && len != 0) begin
            n = len;
            if (n > PB) n = PB;
            if (n > CERT_LEN - off) n = CERT_LEN - off;
            for (int b = 0; b < n; b++) ep[8*b +: 8] = mem[slot*CERT_LEN + off + b];
            eh = {8'h01, 8'h02, 8'(slot), 8'h00}; el = 4 + n;
        end else if (h[23:16] == 8'h83 && m[slot]) begin
            if (cdone) begin
                eh = {8'h01, 8'h03, 8'(slot), 8'h00}; ep = cresp; el = 4 + ((clen > PB) ? PB : clen);
            end else begin
                eh = 32'h017FFF00; el = 4;
            end
        end else begin
            eh = 32'h017F0100; el = 4;
        end
        return {eh, 16'(el), ep};
    endfunction

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic wait_pending(input int bound, output int waited);
        waited = 0;
        while (!pending_auth_msg_to_send && waited < bound) begin
            tick;
            waited++;
        end
        if (!pending_auth_msg_to_send) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no response after %0d cycles", waited);
        end
    endtask

    task automatic issue_and_wait(input logic [31:0] h, input logic [255:0] pl, input int cdelay,
                                  input int clen, output int waited);
        logic [PW-1:0] cresp;
        int n, i;
        bit engine;
        cresp = '0;
        n = (clen > PB) ? PB : clen;
        for (int b = 0; b < n; b++) cresp[8*b +: 8] = 8'($urandom);
        exp_q.push_back(model(h, pl, slot_mask, cresp, clen, cdelay >= 0));
        engine    = (h[31:24] == 8'h01) && (h[23:16] == 8'h83) && slot_mask[h[9:8]];
        chal_resp = cresp;
        chal_len  = 16'(clen);
        header_in = h;
        for (int w = 0; w < PW/32; w++) payload_in[32*w +: 32] = $urandom;
        payload_in[255:0] = pl;
        msg_req_in = 1'b1;
        tick;
        msg_req_in = 1'b0;
        chk("ack_out", 64'(Ack_out), 64'd1);
        if (engine) begin
            i = 0;
            tick;
            while (!chal_start && i < 4) begin
                tick;
                i++;
            end
            chk("chal_start", 64'(chal_start), 64'd1);
            chk("chal_slot", 64'(chal_slot), 64'(h[9:8]));
            checks++;
            if (chal_nonce !== pl) begin
                errors++;
                $display("FAIL chal_nonce: got %h expected %h", chal_nonce, pl);
            end
            if (cdelay >= 0) begin
                repeat (cdelay) tick;
                chal_done = 1'b1;
                tick;
                chal_done = 1'b0;
            end
        end
        wait_pending(6000, waited);
    endtask

    task automatic ack_resp(input int delay);
        repeat (delay) tick;
        Ack_in = 1'b1;
        tick;
        Ack_in = 1'b0;
        chk("pending_drop", 64'(pending_auth_msg_to_send), 64'd0);
        tick;
    endtask

    function automatic logic [255:0] rand_pl();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard monitor
    logic          in_msg = 1'b0;
    logic [RW-1:0] snap;
    logic [RW-1:0] e;
    int            fb;

    always @(negedge clk) begin
        if (!reset) begin
            in_msg = 1'b0;
        end else if (pending_auth_msg_to_send) begin
            if (!in_msg) begin
                in_msg = 1'b1;
                snap = {header, wLength, payload};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: header %h with no expected response", header);
                end else begin
                    e = exp_q.pop_front();
                    if (snap !== e) begin
                        errors++;
                        fb = 0;
                        for (int b = PB-1; b >= 0; b--) if (snap[8*b +: 8] !== e[8*b +: 8]) fb = b;
                        $display("FAIL resp: header %h expected %h, wLength %0d expected %0d, byte %0d got %h expected %h",
                                 snap[RW-1 -: 32], e[RW-1 -: 32], snap[PW +: 16], e[PW +: 16],
                                 fb, snap[8*fb +: 8], e[8*fb +: 8]);
                    end
                end
            end else begin
                checks++;
                if ({header, wLength, payload} !== snap) begin
                    errors++;
                    $display("FAIL resp_stable: header %h was %h, wLength %0d was %0d",
                             header, snap[RW-1 -: 32], wLength, snap[PW +: 16]);
                end
            end
        end else begin
            in_msg = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en) addr_log.push_back(mem_addr);
    end

    // Stimulus
    initial begin
        int waited, kind, cd, cl;
        logic [31:0] h;
        logic [255:0] pl;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        reset = 1'b1; msg_req_in = 1'b0; header_in = '0; payload_in = '0; Ack_in = 1'b0;
        slot_mask = '0; chal_done = 1'b0; chal_resp = '0; chal_len = '0;
        #2 reset = 1'b0;
        repeat (3) tick;
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_pending", 64'(pending_auth_msg_to_send), 64'd0);
        chk("rst_header", 64'(header), 64'd0);
        chk("rst_wlength", 64'(wLength), 64'd0);
        chk("rst_payload", 64'(|payload), 64'd0);
        chk("rst_ack_out", 64'(Ack_out), 64'd0);
        reset = 1'b1;
        tick;

        // GET_DIGESTS with slots 0 and 2 populated
        slot_mask = 4'b0101;
        issue_and_wait(32'h01810000, rand_pl(), 0, 0, waited);
        ack_resp(1);

        // GET_CERTIFICATE slot1 offset 500 length 64: clipped to 12 bytes at 1012..1023
        slot_mask = 4'b0010;
        addr_log.delete();
        pl = rand_pl(); pl[15:0] = 16'd500; pl[31:16] = 16'd64;
        issue_and_wait(32'h01820100, pl, 0, 0, waited);
        chk("cert_rd_count", 64'(addr_log.size()), 64'd12);
        for (int i = 0; i < addr_log.size() && i < 12; i++)
            chk("cert_rd_addr", 64'(addr_log[i]), 64'(1012 + i));
        ack_resp(0);

        // Certificate boundaries: offset at end, zero length, length beyond payload size
        slot_mask = 4'b1111;
        pl = rand_pl(); pl[15:0] = 16'd512; pl[31:16] = 16'd4;
        issue_and_wait(32'h01820200, pl, 0, 0, waited); ack_resp(0);
        pl = rand_pl(); pl[15:0] = 16'd0; pl[31:16] = 16'd0;
        issue_and_wait(32'h01820300, pl, 0, 0, waited); ack_resp(0);
        pl = rand_pl(); pl[15:0] = 16'd0; pl[31:16] = 16'd300;
        issue_and_wait(32'h01820300, pl, 0, 0, waited); ack_resp(2);

        // CHALLENGE answered after 10 cycles, then never answered
        slot_mask = 4'b0001;
        issue_and_wait(32'h01830000, rand_pl(), 10, 100, waited); ack_resp(0);
        issue_and_wait(32'h01830000, rand_pl(), -1, 0, waited);
        // 4096 waiting cycles, then one cycle building the error
        chk("chal_timeout_cycles", 64'(waited), 64'd4097);
        ack_resp(0);

        // Error cases
        issue_and_wait(32'h02810000, rand_pl(), 0, 0, waited); ack_resp(0);
        issue_and_wait(32'h01840000, rand_pl(), 0, 0, waited); ack_resp(0);
        pl = rand_pl(); pl[15:0] = 16'd0; pl[31:16] = 16'd8;
        issue_and_wait(32'h01820200, pl, 0, 0, waited); ack_resp(0);

        // Ack held off for 20 cycles with requests knocking; then Ack and request together
        slot_mask = 4'b1111;
        issue_and_wait(32'h01810000, rand_pl(), 0, 0, waited);
        for (int i = 0; i < 20; i++) begin
            msg_req_in = (i >= 5 && i < 10);
            header_in  = 32'h01820300;
            chk("busy_ack_out", 64'(Ack_out), 64'd0);
            chk("busy_pending", 64'(pending_auth_msg_to_send), 64'd1);
            tick;
        end
        pl = rand_pl(); pl[15:0] = 16'd0; pl[31:16] = 16'd16;
        exp_q.push_back(model(32'h01820300, pl, slot_mask, '0, 0, 1'b0));
        header_in = 32'h01820300;
        payload_in[255:0] = pl;
        msg_req_in = 1'b1;
        Ack_in = 1'b1;
        tick;
        Ack_in = 1'b0;
        chk("ack_concurrent_e0", 64'(Ack_out), 64'd0);
        tick;
        chk("ack_concurrent_e1", 64'(Ack_out), 64'd0);
        tick;
        chk("ack_concurrent_e2", 64'(Ack_out), 64'd1);
        msg_req_in = 1'b0;
        wait_pending(6000, waited);
        ack_resp(0);

        // Reset in the middle of a certificate read
        pl = rand_pl(); pl[15:0] = 16'd0; pl[31:16] = 16'd128;
        header_in = 32'h01820200;
        payload_in[255:0] = pl;
        msg_req_in = 1'b1;
        tick;
        msg_req_in = 1'b0;
        repeat (20) tick;
        reset = 1'b0;
        #1;
        chk("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_header", 64'(header), 64'd0);
        chk("midrst_payload", 64'(|payload), 64'd0);
        chk("midrst_wlength", 64'(wLength), 64'd0);
        chk("midrst_state", 64'(dbg_state), 64'd0);
        tick;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("postrst_quiet", 64'({Ack_out, pending_auth_msg_to_send}), 64'd0);
        end
        pl = rand_pl(); pl[15:0] = 16'd100; pl[31:16] = 16'd50;
        issue_and_wait(32'h01820200, pl, 0, 0, waited); ack_resp(0);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            slot_mask = 4'($urandom);
            kind = $urandom_range(0, 5);
            pl = rand_pl();
            cd = $urandom_range(0, 20);
            cl = $urandom_range(0, 200);
            case (kind)
                0: h = 32'h01810000;
                1: begin
                    h = {8'h01, 8'h82, 6'd0, 2'($urandom), 8'h00};
                    pl[15:0] = 16'($urandom_range(0, 600)); pl[31:16] = 16'($urandom_range(0, 300));
                end
                2: h = {8'h01, 8'h83, 6'd0, 2'($urandom), 8'h00};
                3: h = {8'h01, 8'(8'h84 + $urandom_range(0, 9)), 8'h00, 8'h00};
                4: h = {8'($urandom_range(2, 255)), 8'h81, 8'h00, 8'h00};
                default: begin
                    h = {8'h01, 8'h82, 6'd0, 2'($urandom), 8'h00};
                    pl[15:0] = 16'(CERT_LEN - $urandom_range(1, 20)); pl[31:16] = 16'($urandom_range(1, 40));
                end
            endcase
            issue_and_wait(h, pl, cd, cl, waited);
            ack_resp($urandom_range(0, 3));
        end

        repeat (3) tick;
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
